fan_countdown_timer: RTL and testbench



---
 rtl/fan_timer_pkg.sv | 23 ++
 rtl/fan_countdown_timer_prescaler.sv | 41 ++++
 rtl/fan_countdown_timer.sv | 126 ++++++++++++
 tb/tb_fan_countdown_timer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_timer_pkg.sv
// Shared definitions for the fan countdown timer: state encoding, centisecond
// ceiling and the elaboration-time preset value function.
package fan_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic [6:0] CSEC_MAX = 7'd99;

    // Only ever called with constant arguments, so it folds to a constant table.
    function automatic int preset_value(input int k, input int step, input int max_sec);
        int v;
        v = (k + 1) * step;
        if (v > max_sec) begin
            v = max_sec;
        end
        return v;
    endfunction

endpackage

// File: rtl/fan_countdown_timer_prescaler.sv
// Divides the millisecond strobe down to one centisecond step; the step is
// asserted combinationally on the tick that completes the count.
module tick_prescaler #(
    parameter int TICKS_PER_CSEC = 10
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_en,
    input  logic i_tick,
    output logic o_csec_step
);

    localparam int CW = (TICKS_PER_CSEC > 1) ? $clog2(TICKS_PER_CSEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_CSEC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last;

    always_comb begin
        at_last = (cnt_q == LAST);
        cnt_d   = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_en && i_tick) begin
            cnt_d = at_last ? '0 : cnt_q + CW'(1);
        end
    end

    assign o_csec_step = i_en & i_tick & at_last;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fan_countdown_timer.sv
// Preset-loaded seconds/centiseconds countdown with pause, cancel and a
// one-cycle expiry pulse; drives the display digits and the fan enable.
module fan_countdown_timer
    import fan_timer_pkg::*;
#(
    parameter int NUM_PRESETS     = 3,
    parameter int PRESET_STEP_SEC = 10,
    parameter int MAX_SEC         = 99,
    parameter int SEC_W           = 7,
    parameter int TICKS_PER_CSEC  = 10
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_tick,
    input  logic [NUM_PRESETS-1:0] i_preset,
    input  logic                   i_pause_toggle,
    input  logic                   i_cancel,
    output logic [SEC_W-1:0]       o_sec,
    output logic [6:0]             o_csec,
    output logic [1:0]             o_state,
    output logic                   o_fan_en,
    output logic                   o_done
);

    logic [SEC_W-1:0] preset_tbl [NUM_PRESETS];
    logic [SEC_W-1:0] preset_sel;
    logic             any_preset;
    logic             presc_clear;
    logic             presc_en;
    logic             csec_step;

    state_e           state_q, state_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [6:0]       csec_q, csec_d;
    logic             fan_en_q, fan_en_d;
    logic             done_q, done_d;

    generate
        for (genvar gi = 0; gi < NUM_PRESETS; gi++) begin : g_preset
            assign preset_tbl[gi] = SEC_W'(preset_value(gi, PRESET_STEP_SEC, MAX_SEC));
        end
    endgenerate

    // Descending scan so the lowest set request index is the one that sticks.
    always_comb begin
        preset_sel = '0;
        for (int k = NUM_PRESETS - 1; k >= 0; k--) begin
            if (i_preset[k]) begin
                preset_sel = preset_tbl[k];
            end
        end
    end

    assign any_preset  = |i_preset;
    assign presc_clear = i_cancel | any_preset;
    assign presc_en    = (state_q == ST_RUN) & ~i_cancel & ~any_preset & ~i_pause_toggle;

    tick_prescaler #(
        .TICKS_PER_CSEC(TICKS_PER_CSEC)
    ) u_prescaler (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (presc_clear),
        .i_en       (presc_en),
        .i_tick     (i_tick),
        .o_csec_step(csec_step)
    );

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        csec_d  = csec_q;
        done_d  = 1'b0;
        if (i_cancel) begin
            state_d = ST_IDLE;
            sec_d   = '0;
            csec_d  = '0;
        end else if (any_preset) begin
            state_d = ST_RUN;
            sec_d   = preset_sel;
            csec_d  = '0;
        end else if (i_pause_toggle) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSE;
            end else if (state_q == ST_PAUSE) begin
                state_d = ST_RUN;
            end
        end else if (csec_step) begin
            // csec<=1 also covers the zero-valued preset so it expires instead of wrapping.
            if (sec_q == '0 && csec_q <= 7'd1) begin
                state_d = ST_IDLE;
                csec_d  = '0;
                done_d  = 1'b1;
            end else if (csec_q == '0) begin
                csec_d = CSEC_MAX;
                sec_d  = sec_q - SEC_W'(1);
            end else begin
                csec_d = csec_q - 7'd1;
            end
        end
        fan_en_d = (state_d == ST_RUN);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            sec_q    <= '0;
            csec_q   <= '0;
            fan_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sec_q    <= sec_d;
            csec_q   <= csec_d;
            fan_en_q <= fan_en_d;
            done_q   <= done_d;
        end
    end

    assign o_sec    = sec_q;
    assign o_csec   = csec_q;
    assign o_state  = state_q;
    assign o_fan_en = fan_en_q;
    assign o_done   = done_q;

endmodule

// File: tb/tb_fan_countdown_timer.sv
// Scoreboard bench: dut_a runs one tick per centisecond with 3 presets,
// dut_b runs ten ticks per centisecond with 12 presets (saturating).
module tb_fan_countdown_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        pause;
    logic        cancel;
    logic [2:0]  pa;
    logic [11:0] pb;

    logic [6:0]  a_sec, a_csec, b_sec, b_csec;
    logic [1:0]  a_state, b_state;
    logic        a_fan, a_done, b_fan, b_done;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int    due;
        int    id;
        string nm;
        int    sec;
        int    csec;
        int    st;
        int    fan;
        int    done;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fan_countdown_timer #(
        .NUM_PRESETS(3), .PRESET_STEP_SEC(10), .MAX_SEC(99), .SEC_W(7), .TICKS_PER_CSEC(1)
    ) dut_a (
        .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_preset(pa),
        .i_pause_toggle(pause), .i_cancel(cancel),
        .o_sec(a_sec), .o_csec(a_csec), .o_state(a_state), .o_fan_en(a_fan), .o_done(a_done)
    );

    fan_countdown_timer #(
        .NUM_PRESETS(12), .PRESET_STEP_SEC(10), .MAX_SEC(99), .SEC_W(7), .TICKS_PER_CSEC(10)
    ) dut_b (
        .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_preset(pb),
        .i_pause_toggle(pause), .i_cancel(cancel),
        .o_sec(b_sec), .o_csec(b_csec), .o_state(b_state), .o_fan_en(b_fan), .o_done(b_done)
    );

    // Monitor: pops every expectation whose cycle has arrived and compares it.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            int as, ac, ast, af, ad;
            e = sb.pop_front();
            if (e.id == 0) begin
                as = a_sec; ac = a_csec; ast = a_state; af = a_fan; ad = a_done;
            end else begin
                as = b_sec; ac = b_csec; ast = b_state; af = b_fan; ad = b_done;
            end
            checks++;
            if (e.due != cyc || as != e.sec || ac != e.csec || ast != e.st
                || af != e.fan || ad != e.done) begin
                errors++;
                $display("FAIL %s dut%0d cyc=%0d: got sec=%0d csec=%0d st=%0d fan=%0d done=%0d, want sec=%0d csec=%0d st=%0d fan=%0d done=%0d (due %0d)",
                         e.nm, e.id, cyc, as, ac, ast, af, ad,
                         e.sec, e.csec, e.st, e.fan, e.done, e.due);
            end else begin
                $display("chk %s dut%0d cyc=%0d sec=%0d csec=%0d st=%0d fan=%0d done=%0d ok",
                         e.nm, e.id, cyc, as, ac, ast, af, ad);
            end
        end
    end

    task automatic drive(input logic r, input logic t, input logic p, input logic c,
                         input logic [2:0] a, input logic [11:0] b);
        rst = r; tick = t; pause = p; cancel = c; pa = a; pb = b;
    endtask

    // ofs=1: state after the coming edge; ofs=0: state before it.
    task automatic expect_at(input int ofs, input int id, input string nm, input int s,
                             input int cs, input int st, input int fan, input int dn);
        exp_t e;
        e.due = cyc + ofs; e.id = id; e.nm = nm; e.sec = s; e.csec = cs;
        e.st = st; e.fan = fan; e.done = dn;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 3'b000, 12'h000);
    endtask

    initial begin
        int r;
        drive(1, 0, 0, 0, 3'b000, 12'h000);
        @(posedge clk);
        #1;

        // Reset state
        drive(1, 1, 0, 0, 3'b000, 12'h000);
        expect_at(1, 0, "reset", 0, 0, 0, 0, 0);
        expect_at(1, 1, "reset", 0, 0, 0, 0, 0);
        step();

        // Preset index 0 and a full 10.00 s countdown at one tick per csec
        drive(0, 0, 0, 0, 3'b001, 12'h000);
        expect_at(1, 0, "preset0", 10, 0, 1, 1, 0);
        step();
        for (int n = 1; n <= 1000; n++) begin
            r = 1000 - n;
            drive(0, 1, 0, 0, 3'b000, 12'h000);
            if (n < 1000) expect_at(1, 0, "run1k", r / 100, r % 100, 1, 1, 0);
            else          expect_at(1, 0, "expire", 0, 0, 0, 0, 1);
            step();
        end
        for (int n = 0; n < 3; n++) begin
            drive(0, 1, 0, 0, 3'b000, 12'h000);
            expect_at(1, 0, "post_expire", 0, 0, 0, 0, 0);
            step();
        end
        expect_at(1, 1, "b_idle", 0, 0, 0, 0, 0);

        // Lowest set bit wins; cancel beats preset
        drive(0, 0, 0, 0, 3'b110, 12'h000);
        expect_at(1, 0, "preset_110", 20, 0, 1, 1, 0);
        step();
        drive(0, 1, 0, 1, 3'b110, 12'h000);
        expect_at(1, 0, "cancel_preset", 0, 0, 0, 0, 0);
        step();

        // Pause freezes counters; ticks during pause ignored
        drive(0, 0, 0, 0, 3'b001, 12'h000);
        expect_at(1, 0, "preset0b", 10, 0, 1, 1, 0);
        step();
        for (int n = 1; n <= 5; n++) begin
            drive(0, 1, 0, 0, 3'b000, 12'h000);
            expect_at(1, 0, "pre_pause", 9, 100 - n, 1, 1, 0);
            step();
        end
        drive(0, 0, 1, 0, 3'b000, 12'h000);
        expect_at(1, 0, "pause", 9, 95, 2, 0, 0);
        step();
        for (int n = 0; n < 50; n++) begin
            drive(0, 1, 0, 0, 3'b000, 12'h000);
            expect_at(1, 0, "paused_tick", 9, 95, 2, 0, 0);
            step();
        end
        drive(0, 0, 1, 0, 3'b000, 12'h000);
        expect_at(1, 0, "resume", 9, 95, 1, 1, 0);
        step();
        drive(0, 1, 0, 0, 3'b000, 12'h000);
        expect_at(1, 0, "resumed_tick", 9, 94, 1, 1, 0);
        step();

        // Pause toggle in IDLE is ignored
        drive(0, 0, 0, 1, 3'b000, 12'h000);
        expect_at(1, 0, "cancel", 0, 0, 0, 0, 0);
        step();
        drive(0, 1, 1, 0, 3'b000, 12'h000);
        expect_at(1, 0, "idle_pause", 0, 0, 0, 0, 0);
        step();

        // Preset on the expiry cycle reloads without o_done
        drive(0, 0, 0, 0, 3'b001, 12'h000);
        expect_at(1, 0, "preset0c", 10, 0, 1, 1, 0);
        step();
        for (int n = 1; n <= 999; n++) begin
            drive(0, 1, 0, 0, 3'b000, 12'h000);
            if (n == 999) expect_at(1, 0, "at_0_01", 0, 1, 1, 1, 0);
            step();
        end
        drive(0, 1, 0, 0, 3'b010, 12'h000);
        expect_at(1, 0, "preset_on_expiry", 20, 0, 1, 1, 0);
        step();
        expect_at(1, 0, "no_done_after", 20, 0, 1, 1, 0);
        step();

        // Reset mid-run at 7.42; reset without an edge changes nothing
        drive(0, 0, 0, 0, 3'b001, 12'h000);
        expect_at(1, 0, "preset0d", 10, 0, 1, 1, 0);
        step();
        for (int n = 1; n <= 258; n++) begin
            drive(0, 1, 0, 0, 3'b000, 12'h000);
            if (n == 258) expect_at(1, 0, "at_7_42", 7, 42, 1, 1, 0);
            step();
        end
        drive(1, 0, 0, 0, 3'b000, 12'h000);
        expect_at(0, 0, "reset_no_edge", 7, 42, 1, 1, 0);
        expect_at(1, 0, "reset_mid_run", 0, 0, 0, 0, 0);
        step();

        // dut_b: 12 presets with saturation, ten ticks per centisecond
        drive(0, 0, 0, 0, 3'b000, 12'h100);
        expect_at(1, 1, "b_preset8", 90, 0, 1, 1, 0);
        step();
        drive(0, 0, 0, 0, 3'b000, 12'h800);
        expect_at(1, 1, "b_preset11_sat", 99, 0, 1, 1, 0);
        step();
        expect_at(1, 0, "a_idle", 0, 0, 0, 0, 0);
        for (int n = 1; n <= 10; n++) begin
            drive(0, 1, 0, 0, 3'b000, 12'h000);
            if (n < 10) expect_at(1, 1, "b_presc", 99, 0, 1, 1, 0);
            else        expect_at(1, 1, "b_step10", 98, 99, 1, 1, 0);
            step();
        end
        for (int n = 1; n <= 5; n++) begin
            drive(0, 1, 0, 0, 3'b000, 12'h000);
            step();
        end
        drive(0, 0, 0, 0, 3'b000, 12'h800);
        expect_at(1, 1, "b_reload", 99, 0, 1, 1, 0);
        step();
        for (int n = 1; n <= 10; n++) begin
            drive(0, 1, 0, 0, 3'b000, 12'h000);
            if (n < 10) expect_at(1, 1, "b_presc_clr", 99, 0, 1, 1, 0);
            else        expect_at(1, 1, "b_step_clr", 98, 99, 1, 1, 0);
            step();
        end
        for (int n = 1; n <= 4; n++) begin
            drive(0, 1, 0, 0, 3'b000, 12'h000);
            step();
        end
        drive(0, 0, 1, 0, 3'b000, 12'h000);
        expect_at(1, 1, "b_pause", 98, 99, 2, 0, 0);
        step();
        for (int n = 0; n < 20; n++) begin
            drive(0, 1, 0, 0, 3'b000, 12'h000);
            expect_at(1, 1, "b_paused", 98, 99, 2, 0, 0);
            step();
        end
        drive(0, 0, 1, 0, 3'b000, 12'h000);
        expect_at(1, 1, "b_resume", 98, 99, 1, 1, 0);
        step();
        for (int n = 1; n <= 6; n++) begin
            drive(0, 1, 0, 0, 3'b000, 12'h000);
            if (n < 6) expect_at(1, 1, "b_presc_held", 98, 99, 1, 1, 0);
            else       expect_at(1, 1, "b_step_held", 98, 98, 1, 1, 0);
            step();
        end
        drive(0, 0, 0, 1, 3'b000, 12'h000);
        expect_at(1, 1, "b_cancel", 0, 0, 0, 0, 0);
        step();

        // Bounded drain of the scoreboard
        for (int n = 0; n < 5 && sb.size() > 0; n++) begin
            step();
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
